// File: rtl/hierarchy_ift_pkg.sv
// Shared types and the precise AND taint-propagation rule for the hierarchy IFT slice.
package hierarchy_ift_pkg;

    localparam int unsigned TW = 32;

    typedef logic [TW-1:0] taint_t;

    // An operand only contributes its label when the other operand is live,
    // i.e. could let it reach the result (value 1 or itself tainted).
    function automatic taint_t and_taint(input logic a, input taint_t a_t,
                                         input logic b, input taint_t b_t);
        logic a_live;
        logic b_live;
        taint_t ta;
        taint_t tb;
        a_live = a | (|a_t);
        b_live = b | (|b_t);
        ta     = b_live ? a_t : '0;
        tb     = a_live ? b_t : '0;
        return ta | tb;
    endfunction

endpackage

// File: rtl/hierarchy_ift_and_ift_cell.sv
// Combinational tracking cell: 1-bit AND plus its 32-bit taint label.
module and_ift_cell
    import hierarchy_ift_pkg::*;
(
    input  logic          a,
    input  logic [TW-1:0] a_t,
    input  logic          b,
    input  logic [TW-1:0] b_t,
    output logic          y,
    output logic [TW-1:0] y_t
);

    always_comb begin
        y   = a & b;
        y_t = and_taint(a, a_t, b, b_t);
    end

endmodule

// File: rtl/hierarchy_ift.sv
// Top of the hierarchy IFT slice: one tracking cell followed by the output register.
module hierarchy_ift
    import hierarchy_ift_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a,
    input  logic [TW-1:0] a_t,
    input  logic          b,
    input  logic [TW-1:0] b_t,
    output logic          c,
    output logic [TW-1:0] c_t
);

    logic          c_next;
    logic [TW-1:0] c_t_next;

    and_ift_cell u_cell (
        .a   (a),
        .a_t (a_t),
        .b   (b),
        .b_t (b_t),
        .y   (c_next),
        .y_t (c_t_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c   <= 1'b0;
            c_t <= '0;
        end else begin
            c   <= c_next;
            c_t <= c_t_next;
        end
    end

endmodule

// File: tb/tb_hierarchy_ift.sv
// Scoreboard bench for hierarchy_ift: expected results queued at drive time, popped after the edge.
module tb_hierarchy_ift;
    import hierarchy_ift_pkg::*;

    typedef struct packed {
        logic   c;
        taint_t ct;
    } exp_t;

    logic   clk;
    logic   rst_n;
    logic   a;
    taint_t a_t;
    logic   b;
    taint_t b_t;
    logic   c;
    taint_t c_t;

    exp_t sb[$];
    exp_t e;
    int   checks;
    int   errors;

    hierarchy_ift dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .a_t   (a_t),
        .b     (b),
        .b_t   (b_t),
        .c     (c),
        .c_t   (c_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent per-bit reference: bit i of the label survives if its owner
    // operand carries it and the opposite operand can pass it through.
    function automatic taint_t ref_taint(input logic ra, input taint_t rat,
                                         input logic rb, input taint_t rbt);
        taint_t r;
        logic a_pass;
        logic b_pass;
        a_pass = (ra == 1'b1) || (rat != 0);
        b_pass = (rb == 1'b1) || (rbt != 0);
        for (int i = 0; i < int'(TW); i++)
            r[i] = (rat[i] && b_pass) || (rbt[i] && a_pass);
        return r;
    endfunction

    task automatic apply(input logic ia, input taint_t iat, input logic ib, input taint_t ibt,
                         input logic ec, input taint_t ect);
        @(negedge clk);
        a = ia; a_t = iat; b = ib; b_t = ibt;
        sb.push_back('{c: ec, ct: ect});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = 1'b1; b = 1'b1; a_t = '1; b_t = '1;
        #2;
        checks++;
        if (c !== 1'b0 || c_t !== '0) begin
            errors++;
            $display("FAIL reset_immediate: c=%0b c_t=%h, expected c=0 c_t=00000000", c, c_t);
        end
        @(posedge clk); #1;
        checks++;
        if (c !== 1'b0 || c_t !== '0) begin
            errors++;
            $display("FAIL reset_hold: c=%0b c_t=%h, expected c=0 c_t=00000000", c, c_t);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{c: 1'b1, ct: 32'hFFFF_FFFF});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (c !== e.c || c_t !== e.ct) begin
            errors++;
            $display("FAIL reset_release: c=%0b c_t=%h, expected c=%0b c_t=%h", c, c_t, e.c, e.ct);
        end
    endtask

    task automatic test_truth_table();
        logic [3:0] exp_c;
        exp_c = 4'b1000;
        for (int unsigned i = 0; i < 4; i++) begin
            apply(i[1], '0, i[0], '0, exp_c[i], '0);
            e = sb.pop_front();
            checks++;
            if (c !== e.c || c_t !== e.ct) begin
                errors++;
                $display("FAIL truth_%0d: c=%0b c_t=%h, expected c=%0b c_t=%h", i, c, c_t, e.c, e.ct);
            end
        end
    endtask

    task automatic test_masking();
        apply(1'b0, '0, 1'b1, 32'h2, 1'b0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (c !== e.c || c_t !== e.ct) begin
            errors++;
            $display("FAIL mask_zero: c=%0b c_t=%h, expected c=%0b c_t=%h", c, c_t, e.c, e.ct);
        end
        apply(1'b1, '0, 1'b1, 32'h2, 1'b1, 32'h2);
        e = sb.pop_front();
        checks++;
        if (c !== e.c || c_t !== e.ct) begin
            errors++;
            $display("FAIL mask_pass: c=%0b c_t=%h, expected c=%0b c_t=%h", c, c_t, e.c, e.ct);
        end
    endtask

    task automatic test_merge();
        apply(1'b0, 32'h10, 1'b0, 32'h20, 1'b0, 32'h30);
        e = sb.pop_front();
        checks++;
        if (c !== e.c || c_t !== e.ct) begin
            errors++;
            $display("FAIL merge_both0: c=%0b c_t=%h, expected c=%0b c_t=%h", c, c_t, e.c, e.ct);
        end
        apply(1'b0, 32'h1, 1'b1, 32'h2, 1'b0, 32'h3);
        e = sb.pop_front();
        checks++;
        if (c !== e.c || c_t !== e.ct) begin
            errors++;
            $display("FAIL merge_mixed: c=%0b c_t=%h, expected c=%0b c_t=%h", c, c_t, e.c, e.ct);
        end
        apply(1'b0, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (c !== e.c || c_t !== e.ct) begin
            errors++;
            $display("FAIL merge_masked: c=%0b c_t=%h, expected c=%0b c_t=%h", c, c_t, e.c, e.ct);
        end
        apply(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (c !== e.c || c_t !== e.ct) begin
            errors++;
            $display("FAIL merge_msb_masked: c=%0b c_t=%h, expected c=%0b c_t=%h", c, c_t, e.c, e.ct);
        end
    endtask

    // New inputs every cycle; outputs must hold the previous result until the edge.
    task automatic test_back_to_back();
        logic   ra;
        logic   rb;
        taint_t rat;
        taint_t rbt;
        exp_t   prev;
        @(negedge clk);
        prev = '{c: c, ct: c_t};
        for (int n = 0; n < 200; n++) begin
            ra  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            rat = ($urandom_range(0, 2) == 0) ? '0 : ($urandom & $urandom);
            rbt = ($urandom_range(0, 2) == 0) ? '0 : ($urandom & $urandom);
            a = ra; a_t = rat; b = rb; b_t = rbt;
            sb.push_back('{c: ra & rb, ct: ref_taint(ra, rat, rb, rbt)});
            #1;
            checks++;
            if (c !== prev.c || c_t !== prev.ct) begin
                errors++;
                $display("FAIL b2b_hold_%0d: c=%0b c_t=%h, expected c=%0b c_t=%h", n, c, c_t, prev.c, prev.ct);
            end
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b2b_empty_%0d: scoreboard empty, expected one entry", n);
            end else begin
                e = sb.pop_front();
                checks++;
                if (c !== e.c || c_t !== e.ct) begin
                    errors++;
                    $display("FAIL b2b_%0d: c=%0b c_t=%h, expected c=%0b c_t=%h", n, c, c_t, e.c, e.ct);
                end
                prev = e;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 32'h5, 1'b1, 32'hA, 1'b1, 32'hF);
        e = sb.pop_front();
        checks++;
        if (c !== e.c || c_t !== e.ct) begin
            errors++;
            $display("FAIL arst_pre: c=%0b c_t=%h, expected c=%0b c_t=%h", c, c_t, e.c, e.ct);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (c !== 1'b0 || c_t !== '0) begin
            errors++;
            $display("FAIL arst_clear: c=%0b c_t=%h, expected c=0 c_t=00000000", c, c_t);
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (c !== 1'b0 || c_t !== '0) begin
            errors++;
            $display("FAIL arst_no_stale: c=%0b c_t=%h, expected c=0 c_t=00000000", c, c_t);
        end
        sb.push_back('{c: 1'b1, ct: 32'hF});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (c !== e.c || c_t !== e.ct) begin
            errors++;
            $display("FAIL arst_reload: c=%0b c_t=%h, expected c=%0b c_t=%h", c, c_t, e.c, e.ct);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_truth_table();
        test_masking();
        test_merge();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
